// File: rtl/ppt_cmd_rx.sv
// UART 8N1 receiver for presenter remote commands: decodes next/prev/home
// bytes into one-cycle command pulses and maintains a saturating slide index.
module ppt_cmd_rx #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic       rxd,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       frame_err,
  output logic       cmd_next,
  output logic       cmd_prev,
  output logic [7:0] slide_idx,
  output logic       busy
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);
  localparam logic [7:0] BYTE_NEXT = 8'h4E;
  localparam logic [7:0] BYTE_PREV = 8'h50;
  localparam logic [7:0] BYTE_HOME = 8'h48;

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_HIGH} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shreg_q, shreg_d;
  logic [1:0]    sync_q;
  logic [7:0]    rx_data_q, rx_data_d;
  logic [7:0]    slide_q, slide_d;
  logic          valid_q, valid_d;
  logic          ferr_q, ferr_d;
  logic          next_q, next_d;
  logic          prev_q, prev_d;
  logic          rxd_s;

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  function automatic logic [7:0] sat_dec(input logic [7:0] v);
    return (v == 8'h00) ? v : v - 8'd1;
  endfunction

  assign rxd_s = sync_q[1];

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q + 1'b1;
    bit_d     = bit_q;
    shreg_d   = shreg_q;
    rx_data_d = rx_data_q;
    slide_d   = slide_q;
    valid_d   = 1'b0;
    ferr_d    = 1'b0;
    next_d    = 1'b0;
    prev_d    = 1'b0;

    case (state_q)
      IDLE: begin
        cnt_d = '0;
        bit_d = '0;
        if (!rxd_s) state_d = START;
      end
      START: begin
        if (cnt_q == HALF_M1) begin
          cnt_d   = '0;
          bit_d   = '0;
          state_d = rxd_s ? IDLE : DATA;
        end
      end
      DATA: begin
        if (cnt_q == FULL_M1) begin
          cnt_d   = '0;
          shreg_d = {rxd_s, shreg_q[7:1]};
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) state_d = STOP;
        end
      end
      STOP: begin
        if (cnt_q == FULL_M1) begin
          cnt_d = '0;
          if (rxd_s) begin
            rx_data_d = shreg_q;
            valid_d   = 1'b1;
            state_d   = IDLE;
            if (shreg_q == BYTE_NEXT) begin
              next_d  = 1'b1;
              slide_d = sat_inc(slide_q);
            end else if (shreg_q == BYTE_PREV) begin
              prev_d  = 1'b1;
              slide_d = sat_dec(slide_q);
            end else if (shreg_q == BYTE_HOME) begin
              slide_d = 8'h00;
            end
          end else begin
            ferr_d  = 1'b1;
            state_d = WAIT_HIGH;
          end
        end
      end
      WAIT_HIGH: begin
        cnt_d = '0;
        if (rxd_s) state_d = IDLE;
      end
      default: begin
        cnt_d   = '0;
        state_d = IDLE;
      end
    endcase

    // Disable wins over everything: drop the partial frame, keep held results.
    if (!ena) begin
      state_d   = IDLE;
      cnt_d     = '0;
      bit_d     = '0;
      rx_data_d = rx_data_q;
      slide_d   = slide_q;
      valid_d   = 1'b0;
      ferr_d    = 1'b0;
      next_d    = 1'b0;
      prev_d    = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      bit_q     <= '0;
      sync_q    <= 2'b11;
      rx_data_q <= 8'h00;
      slide_q   <= 8'h00;
      valid_q   <= 1'b0;
      ferr_q    <= 1'b0;
      next_q    <= 1'b0;
      prev_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_q     <= bit_d;
      sync_q    <= {sync_q[0], rxd};
      rx_data_q <= rx_data_d;
      slide_q   <= slide_d;
      valid_q   <= valid_d;
      ferr_q    <= ferr_d;
      next_q    <= next_d;
      prev_q    <= prev_d;
    end
  end

  // Shift register holds only in-flight data; it is always overwritten before use.
  always_ff @(posedge clk) begin
    shreg_q <= shreg_d;
  end

  assign rx_data   = rx_data_q;
  assign rx_valid  = valid_q;
  assign frame_err = ferr_q;
  assign cmd_next  = next_q;
  assign cmd_prev  = prev_q;
  assign slide_idx = slide_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_ppt_cmd_rx.sv
// Scoreboard bench for ppt_cmd_rx: stimulus pushes expected responses, a
// monitor pops and compares on every output pulse.
module tb_ppt_cmd_rx;

  localparam int CPB = 16;

  logic       clk;
  logic       rst_n;
  logic       ena;
  logic       rxd;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       frame_err;
  logic       cmd_next;
  logic       cmd_prev;
  logic [7:0] slide_idx;
  logic       busy;

  // {frame_err, rx_valid, cmd_next, cmd_prev, rx_data, slide_idx}
  logic [19:0] sb[$];
  int          checks;
  int          failures;
  logic [7:0]  m_slide;
  logic [7:0]  m_data;

  ppt_cmd_rx #(.CLKS_PER_BIT(CPB)) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .rxd(rxd),
    .rx_data(rx_data), .rx_valid(rx_valid), .frame_err(frame_err),
    .cmd_next(cmd_next), .cmd_prev(cmd_prev), .slide_idx(slide_idx),
    .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Expected response for a good frame, advancing the reference slide index.
  task automatic expect_good(input logic [7:0] b);
    logic nx;
    logic pv;
    nx = (b == 8'h4E);
    pv = (b == 8'h50);
    if (nx && m_slide != 8'd255) m_slide = m_slide + 8'd1;
    if (pv && m_slide != 8'd0)   m_slide = m_slide - 8'd1;
    if (b == 8'h48)              m_slide = 8'd0;
    m_data = b;
    sb.push_back({1'b0, 1'b1, nx, pv, b, m_slide});
  endtask

  task automatic send_bits(input logic [7:0] b);
    rxd = 1'b0;
    repeat (CPB) @(posedge clk);
    for (int i = 0; i < 8; i++) begin
      rxd = b[i];
      repeat (CPB) @(posedge clk);
    end
  endtask

  task automatic send_frame(input logic [7:0] b);
    send_bits(b);
    rxd = 1'b1;
    repeat (CPB + 2) @(posedge clk);
  endtask

  // Monitor: every output pulse must match the head of the scoreboard.
  initial begin
    forever begin
      @(negedge clk);
      if (rx_valid || frame_err || cmd_next || cmd_prev) begin
        if (sb.size() == 0)
          chk("unexpected_pulse", {12'h0, frame_err, rx_valid, cmd_next, cmd_prev, rx_data, slide_idx}, 32'h0);
        else
          chk("response", {12'h0, frame_err, rx_valid, cmd_next, cmd_prev, rx_data, slide_idx},
              {12'h0, sb.pop_front()});
      end
    end
  end

  initial begin
    #2ms;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit seen;
    checks   = 0;
    failures = 0;
    m_slide  = 8'h00;
    m_data   = 8'h00;
    rst_n    = 1'b0;
    ena      = 1'b1;
    rxd      = 1'b1;

    #20;
    chk("reset_outputs", {rx_valid, frame_err, cmd_next, cmd_prev, busy, rx_data, slide_idx}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(posedge clk);

    // next, prev, prev at zero
    expect_good(8'h4E); send_frame(8'h4E);
    chk("slide_after_next", slide_idx, 8'd1);
    expect_good(8'h50); send_frame(8'h50);
    chk("slide_after_prev", slide_idx, 8'd0);
    expect_good(8'h50); send_frame(8'h50);
    chk("slide_prev_floor", slide_idx, 8'd0);
    chk("rx_data_hold", rx_data, 8'h50);

    // saturate at 255
    for (int i = 1; i <= 256; i++) begin
      expect_good(8'h4E); send_frame(8'h4E);
      if (i == 255) chk("slide_255", slide_idx, 8'd255);
    end
    chk("slide_sat_255", slide_idx, 8'd255);
    expect_good(8'h48); send_frame(8'h48);
    chk("slide_home", slide_idx, 8'd0);
    expect_good(8'hA3); send_frame(8'hA3);
    chk("rx_data_other", rx_data, 8'hA3);

    // start-bit glitch
    @(posedge clk);
    rxd = 1'b0;
    #40;
    rxd = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (busy) seen = 1'b1;
    end
    chk("glitch_busy_seen", seen, 1'b1);
    repeat (20) @(posedge clk);
    @(negedge clk);
    chk("glitch_idle", busy, 1'b0);

    // framing error with line held low
    @(posedge clk);
    sb.push_back({1'b1, 1'b0, 1'b0, 1'b0, m_data, m_slide});
    send_bits(8'hA5);
    rxd = 1'b0;
    repeat (40) @(posedge clk);
    @(negedge clk);
    chk("ferr_busy_low_line", busy, 1'b1);
    repeat (10) @(posedge clk);
    rxd = 1'b1;
    repeat (5) @(posedge clk);
    @(negedge clk);
    chk("ferr_idle_after_high", busy, 1'b0);
    chk("ferr_rx_data_kept", rx_data, 8'hA3);
    repeat (CPB) @(posedge clk);

    // enable drop mid-frame
    expect_good(8'h4E); send_frame(8'h4E);
    rxd = 1'b0;
    repeat (CPB) @(posedge clk);
    for (int i = 0; i < 3; i++) begin
      rxd = 1'(8'h4E >> i);
      repeat (CPB) @(posedge clk);
    end
    ena = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("ena_abort_busy", busy, 1'b0);
    for (int i = 3; i < 8; i++) begin
      rxd = 1'(8'h4E >> i);
      repeat (CPB) @(posedge clk);
    end
    rxd = 1'b1;
    repeat (CPB) @(posedge clk);
    chk("ena_abort_slide", slide_idx, 8'd1);
    ena = 1'b1;
    repeat (4) @(posedge clk);
    expect_good(8'h50); send_frame(8'h50);
    chk("after_abort_slide", slide_idx, 8'd0);
    chk("after_abort_data", rx_data, 8'h50);

    // reset mid-frame
    expect_good(8'h4E); send_frame(8'h4E);
    rxd = 1'b0;
    repeat (CPB) @(posedge clk);
    rxd = 1'b0;
    repeat (2 * CPB) @(posedge clk);
    rst_n = 1'b0;
    #1;
    chk("midreset_state", {busy, rx_data, slide_idx}, 17'h0);
    m_slide = 8'h00;
    m_data  = 8'h00;
    for (int i = 2; i < 8; i++) begin
      rxd = 1'(8'h4E >> i);
      repeat (CPB) @(posedge clk);
    end
    rxd = 1'b1;
    repeat (CPB) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(posedge clk);
    expect_good(8'h4E); send_frame(8'h4E);
    chk("after_reset_slide", slide_idx, 8'd1);
    chk("after_reset_data", rx_data, 8'h4E);

    repeat (50) @(posedge clk);
    chk("scoreboard_drained", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
